// File: rtl/divider_unit_rv_if.sv
// -----------------------------------------------------------------------------
// divider_unit_rv_if
// Handshake bundle between the mult/div dispatch logic (master) and the
// divide engine (slave).
//
//   in_valid / in_ready    operand handshake (master -> slave)
//   usigned                1 = unsigned divide, 0 = signed divide
//   dividend / divisor     operands, WIDTH bits
//   out_valid / out_ready  result handshake (slave -> master)
//   quotient / reminder    results, WIDTH bits
//   div_by_zero            result came from a zero divisor
//   overflow               result came from signed MIN / -1
// -----------------------------------------------------------------------------
interface divider_unit_rv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             usigned;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] reminder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, usigned, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, reminder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, usigned, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, reminder, div_by_zero, overflow
  );
endinterface

// File: rtl/divider_unit_rv.sv
// -----------------------------------------------------------------------------
// divider_unit_rv
// Iterative restoring divider, signed or unsigned, retiring BITS_PER_CYCLE
// quotient bits per cycle. RISC-V M-extension corner cases (divide by zero,
// signed MIN / -1) bypass the iteration and raise status flags.
//
// Parameters
//   WIDTH           operand/result width, multiple of BITS_PER_CYCLE, >= 8
//   BITS_PER_CYCLE  quotient bits per CALC cycle: 1, 2 or 4
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset; aborts any operation in flight
//   bus   divider_unit_rv_if.slave handshake bundle (operands, results, flags)
//   busy  high whenever the FSM is not in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready=1, waiting for operands
// CALC  | restoring iterations, N = WIDTH/BITS_PER_CYCLE cycles
// FIX   | apply result signs (or corner-case values), register outputs
// DONE  | result presented; held until out_valid & out_ready
// -----------------------------------------------------------------------------
module divider_unit_rv #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  divider_unit_rv_if.slave   bus,
  output logic               busy
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;     // partial remainder between iterations
  logic [WIDTH-1:0] quo_q;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q;     // |divisor|
  logic             neg_quo;
  logic             neg_rem;
  logic             dz_pend;
  logic             ov_pend;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] reminder_q;
  logic             dz_q;
  logic             ov_q;

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.reminder    = reminder_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ov_q;

  // Operand conditioning at accept time. MIN has no positive counterpart in
  // WIDTH signed bits, but -MIN == MIN is exactly |MIN| read as unsigned.
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic             dvs_zero;
  logic             sgn_ovf;

  assign dvd_neg  = !bus.usigned && bus.dividend[WIDTH-1];
  assign dvs_neg  = !bus.usigned && bus.divisor[WIDTH-1];
  assign abs_dvd  = dvd_neg ? -bus.dividend : bus.dividend;
  assign abs_dvs  = dvs_neg ? -bus.divisor  : bus.divisor;
  assign dvs_zero = (bus.divisor == '0);
  assign sgn_ovf  = !bus.usigned && (bus.dividend == MIN_VAL) && (bus.divisor == '1);

  // BITS_PER_CYCLE restoring steps per clock. The shifted remainder needs
  // WIDTH+1 bits because it can reach 2*divisor-1 before the subtract.
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH:0]   r_sh;

  always_comb begin
    r_nx = rem_q;
    q_nx = quo_q;
    r_sh = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      r_sh = {r_nx, q_nx[WIDTH-1]};
      q_nx = {q_nx[WIDTH-2:0], 1'b0};
      if (r_sh >= {1'b0, dvs_q}) begin
        r_sh    = r_sh - {1'b0, dvs_q};
        q_nx[0] = 1'b1;
      end
      // after a restoring step the remainder is below the divisor, so the
      // top bit is always zero here
      r_nx = r_sh[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      dz_pend     <= 1'b0;
      ov_pend     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      quotient_q  <= '0;
      reminder_q  <= '0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            dvs_q      <= abs_dvs;
            cnt        <= CW'(N);
            if (dvs_zero) begin
              // raw dividend passes through untouched, in both modes
              quo_q   <= '1;
              rem_q   <= bus.dividend;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
              dz_pend <= 1'b1;
              ov_pend <= 1'b0;
              state   <= FIX;
            end else if (sgn_ovf) begin
              quo_q   <= MIN_VAL;
              rem_q   <= '0;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
              dz_pend <= 1'b0;
              ov_pend <= 1'b1;
              state   <= FIX;
            end else begin
              quo_q   <= abs_dvd;
              rem_q   <= '0;
              neg_quo <= dvd_neg ^ dvs_neg;
              neg_rem <= dvd_neg;
              dz_pend <= 1'b0;
              ov_pend <= 1'b0;
              state   <= CALC;
            end
          end
        end

        CALC: begin
          rem_q <= r_nx;
          quo_q <= q_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          quotient_q <= neg_quo ? -quo_q : quo_q;
          reminder_q <= neg_rem ? -rem_q : rem_q;
          dz_q       <= dz_pend;
          ov_q       <= ov_pend;
          state      <= DONE;
        end

        DONE: begin
          // out_valid is registered off DONE entry, so the first DONE cycle
          // is a settle cycle for the freshly registered results
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit_rv.sv
// Testbench for divider_unit_rv: three instances (1, 2 and 4 bits per cycle)
// sharing clock and reset. Stimulus pushes expected results into per-lane
// queues; a monitor pops and compares on each output handshake.
module tb_divider_unit_rv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // per-lane stimulus (tb-driven) and observation (DUT-driven)
  logic        iv   [3];
  logic        us   [3];
  logic [31:0] dvd  [3];
  logic [31:0] dvs  [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [31:0] quo  [3];
  logic [31:0] rmd  [3];
  logic        dz   [3];
  logic        of   [3];
  logic        bsy  [3];

  divider_unit_rv_if #(.WIDTH(32)) b0 ();
  divider_unit_rv_if #(.WIDTH(32)) b1 ();
  divider_unit_rv_if #(.WIDTH(32)) b2 ();

  divider_unit_rv #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b0.slave), .busy(bsy[0]));
  divider_unit_rv #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(b1.slave), .busy(bsy[1]));
  divider_unit_rv #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(b2.slave), .busy(bsy[2]));

  assign b0.in_valid = iv[0];  assign b1.in_valid = iv[1];  assign b2.in_valid = iv[2];
  assign b0.usigned  = us[0];  assign b1.usigned  = us[1];  assign b2.usigned  = us[2];
  assign b0.dividend = dvd[0]; assign b1.dividend = dvd[1]; assign b2.dividend = dvd[2];
  assign b0.divisor  = dvs[0]; assign b1.divisor  = dvs[1]; assign b2.divisor  = dvs[2];
  assign b0.out_ready = ordy[0]; assign b1.out_ready = ordy[1]; assign b2.out_ready = ordy[2];
  assign ir[0]  = b0.in_ready;    assign ir[1]  = b1.in_ready;    assign ir[2]  = b2.in_ready;
  assign ov[0]  = b0.out_valid;   assign ov[1]  = b1.out_valid;   assign ov[2]  = b2.out_valid;
  assign quo[0] = b0.quotient;    assign quo[1] = b1.quotient;    assign quo[2] = b2.quotient;
  assign rmd[0] = b0.reminder;    assign rmd[1] = b1.reminder;    assign rmd[2] = b2.reminder;
  assign dz[0]  = b0.div_by_zero; assign dz[1]  = b1.div_by_zero; assign dz[2]  = b2.div_by_zero;
  assign of[0]  = b0.overflow;    assign of[1]  = b1.overflow;    assign of[2]  = b2.overflow;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        of;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  bit seen  [3] = '{0, 0, 0};
  int first [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (ov[l] && !seen[l]) begin
        seen[l]  = 1'b1;
        first[l] = cyc;
      end
      if (ov[l] && ordy[l]) begin
        exp_t e;
        bit   have;
        have = 1'b0;
        case (l)
          0: if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
          1: if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
          default: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output lane%0d: got q=%h r=%h required no result", l, quo[l], rmd[l]);
        end else begin
          chk({e.name, " quotient"}, 96'(quo[l]), 96'(e.q));
          chk({e.name, " reminder"}, 96'(rmd[l]), 96'(e.r));
          chk({e.name, " flags dz,ov"}, 96'({dz[l], of[l]}), 96'({e.dz, e.of}));
          chk({e.name, " latency"}, 96'(first[l] - e.acc), 96'(e.lat));
        end
        seen[l] = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int lane, input string name, input logic u,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input logic eof, input int lat,
                       input bit push, output int acc);
    exp_t e;
    bit   ok;
    ok        = 1'b0;
    acc       = 0;
    iv[lane]  = 1'b1;
    us[lane]  = u;
    dvd[lane] = a;
    dvs[lane] = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ir[lane]) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok  = 1'b1;
        break;
      end
    end
    iv[lane] = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s accept_timeout: got in_ready low for 200 cycles required accept", name);
    end else if (push) begin
      e = '{q: eq, r: er, dz: edz, of: eof, lat: lat, acc: acc, name: name};
      case (lane)
        0: sb0.push_back(e);
        1: sb1.push_back(e);
        default: sb2.push_back(e);
      endcase
    end
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (sb0.size() == 0 && sb1.size() == 0 && sb2.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s drain_timeout: got %0d/%0d/%0d pending required 0", name, sb0.size(), sb1.size(), sb2.size());
    end
  endtask

  int acc;
  int hs;
  bit got;

  initial begin
    for (int l = 0; l < 3; l++) begin
      iv[l] = 1'b0; us[l] = 1'b0; dvd[l] = '0; dvs[l] = '0; ordy[l] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      chk("reset ir,ov,busy", 96'({ir[l], ov[l], bsy[l]}), 96'(3'b100));
      chk("reset results", 96'({quo[l], rmd[l], dz[l], of[l]}), 96'(0));
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // lane 0: 1 bit per cycle
    issue(0, "u_small_by_big", 1'b1, 32'h9F5A87B0, 32'hADCC2209, 32'h00000000, 32'h9F5A87B0, 0, 0, 34, 1, acc);
    issue(0, "s_m7_by_2",      1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 34, 1, acc);
    issue(0, "u_div0",         1'b1, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'h00000064, 1, 0, 2,  1, acc);
    issue(0, "s_div0",         1'b0, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'h00000064, 1, 0, 2,  1, acc);
    issue(0, "s_neg_div0",     1'b0, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB, 1, 0, 2,  1, acc);
    issue(0, "s_min_by_m1",    1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0, 1, 2,  1, acc);
    issue(0, "u_min_by_ones",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, 34, 1, acc);
    issue(0, "u_ones_by_16",   1'b1, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 0, 0, 34, 1, acc);
    issue(0, "s_m100_by_m7",   1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 0, 0, 34, 1, acc);
    issue(0, "s_min_by_2",     1'b0, 32'h80000000, 32'h00000002, 32'hC0000000, 32'h00000000, 0, 0, 34, 1, acc);

    // lanes 1 and 2: 2 and 4 bits per cycle
    issue(1, "r4_s_m7_by_2",   1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 18, 1, acc);
    issue(1, "r4_s_7_by_m2",   1'b0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 0, 0, 18, 1, acc);
    issue(1, "r4_u_ones_by_16",1'b1, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 0, 0, 18, 1, acc);
    issue(2, "r16_s_m7_by_2",  1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 10, 1, acc);
    issue(2, "r16_u_100_by_7", 1'b1, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 0, 0, 10, 1, acc);
    issue(2, "r16_s_min_by_m1",1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0, 1, 2,  1, acc);
    drain("directed");

    // backpressure then back-to-back accept on lane 0
    ordy[0] = 1'b0;
    issue(0, "bp_u_100_by_7", 1'b1, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 0, 0, 34, 1, acc);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ov[0]) begin
        got = 1'b1;
        break;
      end
    end
    chk("bp out_valid seen", 96'(got), 96'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp hold ov,ir,busy,dz,ovf,q,r",
          96'({ov[0], ir[0], bsy[0], dz[0], of[0], quo[0], rmd[0]}),
          96'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000000E, 32'h00000002}));
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    fork
      issue(0, "b2b_s_7_by_m2", 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 0, 0, 34, 1, acc);
      begin
        @(posedge clk);
        #1;
        hs      = cyc;
        ordy[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ordy[0] = 1'b1;
      end
    join
    chk("b2b accept cycle after handshake", 96'(acc - hs), 96'(1));
    drain("backpressure");

    // reset during CALC cycle 5 aborts the operation
    issue(0, "abort", 1'b1, 32'h12345678, 32'h00000003, 32'h0, 32'h0, 0, 0, 0, 0, acc);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midop reset ir,ov,busy", 96'({ir[0], ov[0], bsy[0]}), 96'(3'b100));
    chk("midop reset results", 96'({quo[0], rmd[0], dz[0], of[0]}), 96'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(0, "post_reset_1000_by_7", 1'b1, 32'd1000, 32'd7, 32'd142, 32'd6, 0, 0, 34, 1, acc);
    drain("post_reset");
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
